// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES-128 round sequencer.
// Holds the FSM state encoding, the default round geometry and the op_count width.
package aes_ctrl_pkg;

  localparam int NUM_ROUNDS_DEF = 10;
  localparam int RIDX_W_DEF     = 4;
  localparam int OPC_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round index counter: synchronous clear (priority) and increment, 0-cycle terminal flag.
// The terminal flag marks the last middle round (count == NUM_ROUNDS-1).
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RIDX_W     = RIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [RIDX_W-1:0] cnt,
  output logic              term
);

  logic [RIDX_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign term = (r_cnt == RIDX_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: INIT, middle rounds, FINAL, then holds result until acked.
// Optional op_count output (completed handshakes, saturating) enabled by AES_ROUND_CTRL_PERF_EN.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int RIDX_W     = RIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              ld_state,
  output logic              ld_key,
  output logic              rk_en,
  output logic              sel_final,
  output logic [RIDX_W-1:0] round_idx,
  output logic              out_valid,
  output logic              done
`ifdef AES_ROUND_CTRL_PERF_EN
  ,
  output logic [OPC_W-1:0]  op_count
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_first;
  logic              w_clr;
  logic              w_inc;
  logic              w_ld;
  logic              w_term;
  logic [RIDX_W-1:0] w_cnt;

  aes_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RIDX_W     (RIDX_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .inc  (w_inc),
    .cnt  (w_cnt),
    .term (w_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= (w_state_nxt == DONE) && (r_state != DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_ld        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = INIT;
          w_clr       = 1'b1;
          w_ld        = 1'b1;
        end
      end
      INIT: begin
        w_state_nxt = ROUND;
        w_inc       = 1'b1;
      end
      ROUND: begin
        w_inc = 1'b1;
        if (w_term) w_state_nxt = FINAL;
      end
      FINAL: w_state_nxt = DONE;
      DONE: begin
        // start only counts once the consumer has taken the result
        if (out_ready) begin
          w_clr = 1'b1;
          if (start) begin
            w_state_nxt = INIT;
            w_ld        = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
      end
    endcase
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_clr       = 1'b1;
      w_inc       = 1'b0;
      w_ld        = 1'b0;
    end
  end

  // Load strobes are the one input decode; held low while reset is asserted.
  assign ld_state  = w_ld & rst;
  assign ld_key    = w_ld & rst;
  assign busy      = (r_state == INIT) || (r_state == ROUND) || (r_state == FINAL);
  assign rk_en     = (r_state == INIT) || (r_state == ROUND);
  assign sel_final = (r_state == FINAL);
  assign out_valid = (r_state == DONE);
  assign done      = r_first;
  assign round_idx = w_cnt;

`ifdef AES_ROUND_CTRL_PERF_EN
  logic [OPC_W-1:0] r_op_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_count <= '0;
    end else if (out_valid && out_ready && !abort && (r_op_count != {OPC_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed scenarios plus random start/abort/ready traffic
// compared every cycle against a step-count reference model of the cipher sequence.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          ld_state;
  logic          ld_key;
  logic          rk_en;
  logic          sel_final;
  logic [RW-1:0] round_idx;
  logic          out_valid;
  logic          done;
`ifdef AES_ROUND_CTRL_PERF_EN
  logic [15:0]   op_count;
`endif

  aes_round_ctrl #(.NUM_ROUNDS(NR), .RIDX_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .ld_state  (ld_state),
    .ld_key    (ld_key),
    .rk_en     (rk_en),
    .sel_final (sel_final),
    .round_idx (round_idx),
    .out_valid (out_valid),
    .done      (done)
`ifdef AES_ROUND_CTRL_PERF_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  // Reference model: ph = 0 idle, 1..NR+1 = cycles since start, NR+2 first done cycle, NR+3 held done.
  int   ph = 0;
  int   m_cnt = 0;
  int   cyc_n = 0;
  int   last_done = -1;
  int   prev_done = -1;
  logic obs_ov;
  logic obs_done;

  logic [31:0] w_obs;
  assign w_obs = {17'b0, busy, ld_state, ld_key, rk_en, sel_final, out_valid, done, 8'(round_idx)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] exp_vec(input logic st, input logic ab, input logic rd);
    logic e_busy, e_ld, e_rk, e_sf, e_ov, e_dn;
    int   e_idx;
    e_busy = (ph >= 1) && (ph <= NR + 1);
    e_ld   = rst && st && ((ph == 0) || ((ph >= NR + 2) && rd && !ab));
    e_rk   = (ph >= 1) && (ph <= NR);
    e_sf   = (ph == NR + 1);
    e_ov   = (ph >= NR + 2);
    e_dn   = (ph == NR + 2);
    e_idx  = (ph == 0) ? 0 : ((ph - 1 > NR) ? NR : ph - 1);
    return {17'b0, e_busy, e_ld, e_ld, e_rk, e_sf, e_ov, e_dn, 8'(e_idx)};
  endfunction

  // One clock: drive after posedge, check at negedge, advance model at posedge.
  task automatic cyc(input logic st, input logic ab, input logic rd);
    start     = st;
    abort     = ab;
    out_ready = rd;
    @(negedge clk);
    chk("outputs", w_obs, exp_vec(st, ab, rd));
`ifdef AES_ROUND_CTRL_PERF_EN
    chk("op_count", 32'(op_count), 32'(m_cnt));
`endif
    obs_ov   = out_valid;
    obs_done = done;
    if (done) begin
      prev_done = last_done;
      last_done = cyc_n;
    end
    @(posedge clk);
    if (ab && ph != 0) ph = 0;
    else if (ph == 0) ph = st ? 1 : 0;
    else if (ph <= NR + 1) ph = ph + 1;
    else begin
      if (rd && m_cnt < 65535) m_cnt = m_cnt + 1;
      ph = rd ? (st ? 1 : 0) : NR + 3;
    end
    cyc_n++;
    #1;
  endtask

  task automatic run_to_valid(input logic rd, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b0, rd);
      if (obs_ov) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int nov;
    start = 1'b1;
    #2;
    chk("reset_state", w_obs, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single operation, consumer ready
    cyc(1'b1, 1'b0, 1'b1);
    run_to_valid(1'b1, lat);
    chk("latency", 32'(lat), 32'(NR + 2));
    cyc(1'b0, 1'b0, 1'b0);

    // stalled consumer: result held, done once, start ignored
    cyc(1'b1, 1'b0, 1'b0);
    run_to_valid(1'b0, lat);
    n   = 1;
    nov = 1;
    for (int i = 0; i < 19; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (obs_done) n++;
      if (obs_ov) nov++;
    end
    chk("done_once", 32'(n), 32'd1);
    chk("valid_hold", 32'(nov), 32'd20);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // back-to-back: ack plus start one cycle after the first valid
    cyc(1'b1, 1'b0, 1'b1);
    run_to_valid(1'b0, lat);
    cyc(1'b1, 1'b0, 1'b1);
    run_to_valid(1'b1, lat);
    chk("b2b_gap", 32'(last_done - prev_done), 32'(NR + 3));
    cyc(1'b0, 1'b0, 1'b1);

    // abort at round 5, then a clean operation
    cyc(1'b1, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    chk("abort_at_idx", 32'(round_idx), 32'd5);
    cyc(1'b1, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (obs_done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    run_to_valid(1'b1, lat);
    chk("latency_after_abort", 32'(lat), 32'(NR + 2));
    cyc(1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-cycle at round 7
    cyc(1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    start     = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("pre_rst_idx", 32'(round_idx), 32'd7);
    rst = 1'b0;
    #1;
    chk("async_rst", w_obs, 32'h0);
    ph    = 0;
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0);

`ifdef AES_ROUND_CTRL_PERF_EN
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (k == 2) begin
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
      end else begin
        run_to_valid(1'b1, lat);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("op_count_3", 32'(op_count), 32'd3);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
    end
    abort = 1'b1;
    repeat (2) cyc(1'b0, 1'b1, 1'b0);

`ifdef AES_ROUND_CTRL_PERF_EN
    force dut.r_op_count = 16'hFFFE;
    #1;
    release dut.r_op_count;
    m_cnt = 65534;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      run_to_valid(1'b1, lat);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
